l1_l2_line_bridge: RTL and testbench

- Sits directly downstream of the L1 data cache's L2/memory-side port.
- Converts whole-line requests (fill read, dirty writeback) into a command plus a sequence of narrow data beats on the memory bus.
- Reassembles returned read beats into a full line and presents it back to the L1.
- Handles one outstanding line transaction at a time.

---
 rtl/l1_l2_line_bridge_if.sv | 47 ++++
 rtl/l1_l2_line_bridge.sv | 119 +++++++++++
 tb/tb_l1_l2_line_bridge.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_l2_line_bridge_if.sv
// L1 <-> memory-side bus bundle for the line bridge: L1 line request/response plus
// memory command, write-beat and read-beat channels.
interface l1_l2_line_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BITS  = 512,
  parameter int BEAT_BITS  = 64
);
  logic                  l1_req_valid;
  logic [2:0]            l1_req_type;
  logic [ADDR_WIDTH-1:0] l1_req_addr;
  logic [LINE_BITS-1:0]  l1_req_wdata;
  logic                  l1_ready;
  logic                  l1_resp_valid;
  logic [LINE_BITS-1:0]  l1_resp_rdata;

  logic                  mem_cmd_valid;
  logic                  mem_cmd_ready;
  logic                  mem_cmd_we;
  logic [ADDR_WIDTH-1:0] mem_cmd_addr;
  logic                  mem_wdata_valid;
  logic [BEAT_BITS-1:0]  mem_wdata;
  logic                  mem_wdata_ready;
  logic                  mem_rdata_valid;
  logic [BEAT_BITS-1:0]  mem_rdata;

  // Bridge view
  modport slave (
    input  l1_req_valid, l1_req_type, l1_req_addr, l1_req_wdata,
    output l1_ready, l1_resp_valid, l1_resp_rdata,
    output mem_cmd_valid, mem_cmd_we, mem_cmd_addr,
    input  mem_cmd_ready,
    output mem_wdata_valid, mem_wdata,
    input  mem_wdata_ready,
    input  mem_rdata_valid, mem_rdata
  );

  // Environment view (L1 plus memory)
  modport master (
    output l1_req_valid, l1_req_type, l1_req_addr, l1_req_wdata,
    input  l1_ready, l1_resp_valid, l1_resp_rdata,
    input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr,
    output mem_cmd_ready,
    input  mem_wdata_valid, mem_wdata,
    output mem_wdata_ready,
    output mem_rdata_valid, mem_rdata
  );
endinterface

// File: rtl/l1_l2_line_bridge.sv
// Line <-> beat bridge: one line transaction at a time; cmd 1 cycle after accept, resp 1 cycle after last beat.
// Backpressure: l1_ready low while busy; cmd/write beats stall on ready; read beats cannot be stalled.
module l1_l2_line_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BITS  = 512,
  parameter int BEAT_BITS  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  l1_l2_line_bridge_if.slave    bus,
  output logic                  proto_err,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writebacks
);
  localparam int NUM_BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_W     = $clog2(NUM_BEATS);
  localparam int OFF_W     = $clog2(LINE_BITS / 8);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(NUM_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [2:0]            TYPE_RD   = 3'd0;
  localparam logic [2:0]            TYPE_WB   = 3'd2;

  typedef enum logic [2:0] {IDLE, CMD, WR_BEATS, RD_BEATS, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  is_wb_q;
  logic [LINE_BITS-1:0]  line_buf;
  logic [LINE_BITS-1:0]  rdata_q;
  logic [CNT_W-1:0]      cnt_q;

  logic req_acc, req_ok, cmd_hs, wr_hs, rd_beat, last_beat;

  assign req_acc   = (state_q == IDLE) && bus.l1_req_valid;
  assign req_ok    = (bus.l1_req_type == TYPE_RD) || (bus.l1_req_type == TYPE_WB);
  assign cmd_hs    = (state_q == CMD) && bus.mem_cmd_ready;
  assign wr_hs     = (state_q == WR_BEATS) && bus.mem_wdata_ready;
  assign rd_beat   = (state_q == RD_BEATS) && bus.mem_rdata_valid;
  assign last_beat = (cnt_q == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (req_acc && req_ok) state_d = CMD;
      CMD:      if (cmd_hs) state_d = is_wb_q ? WR_BEATS : RD_BEATS;
      WR_BEATS: if (wr_hs && last_beat) state_d = IDLE;
      RD_BEATS: if (rd_beat && last_beat) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.l1_ready        = 1'b0;
    bus.l1_resp_valid   = 1'b0;
    bus.mem_cmd_valid   = 1'b0;
    bus.mem_cmd_we      = 1'b0;
    bus.mem_wdata_valid = 1'b0;
    bus.mem_wdata       = '0;
    unique case (state_q)
      IDLE:     bus.l1_ready = 1'b1;
      CMD: begin
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_we    = is_wb_q;
      end
      WR_BEATS: begin
        bus.mem_wdata_valid = 1'b1;
        bus.mem_wdata       = line_buf[cnt_q*BEAT_BITS +: BEAT_BITS];
      end
      RESP:     bus.l1_resp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign bus.mem_cmd_addr  = addr_q;
  assign bus.l1_resp_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= '0;
      is_wb_q         <= 1'b0;
      line_buf        <= '0;
      rdata_q         <= '0;
      cnt_q           <= '0;
      proto_err       <= 1'b0;
      stat_reads      <= '0;
      stat_writebacks <= '0;
    end else begin
      if (req_acc) begin
        addr_q   <= bus.l1_req_addr & ~OFF_MASK;
        is_wb_q  <= (bus.l1_req_type == TYPE_WB);
        line_buf <= bus.l1_req_wdata;
      end
      if (req_acc && bus.l1_req_type == TYPE_RD)
        stat_reads <= stat_reads + 32'd1;

      if (state_q == CMD)
        cnt_q <= '0;
      else if (wr_hs || rd_beat)
        cnt_q <= cnt_q + 1'b1;

      // Beats land straight in the response register; it stays untouched outside RD_BEATS
      // so the L1 can sample it late.
      if (rd_beat)
        rdata_q[cnt_q*BEAT_BITS +: BEAT_BITS] <= bus.mem_rdata;

      if (wr_hs && last_beat)
        stat_writebacks <= stat_writebacks + 32'd1;

      if (bus.mem_rdata_valid && state_q != RD_BEATS)
        proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_l1_l2_line_bridge.sv
// Directed bench for l1_l2_line_bridge: fill, writeback with stalls, back-to-back,
// stray beat, reset mid-burst and unsupported request type.
module tb_l1_l2_line_bridge;
  localparam int AW = 32;
  localparam int LB = 512;
  localparam int BB = 64;
  localparam int NB = LB / BB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        proto_err;
  logic [31:0] stat_reads;
  logic [31:0] stat_writebacks;

  int vec_cnt = 0;
  int err_cnt = 0;

  l1_l2_line_bridge_if #(.ADDR_WIDTH(AW), .LINE_BITS(LB), .BEAT_BITS(BB)) bus();

  l1_l2_line_bridge #(.ADDR_WIDTH(AW), .LINE_BITS(LB), .BEAT_BITS(BB)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .proto_err       (proto_err),
    .stat_reads      (stat_reads),
    .stat_writebacks (stat_writebacks)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BB-1:0] beat_pat(input logic [BB-1:0] seed, input int k);
    return seed * 64'(k + 1);
  endfunction

  function automatic logic [LB-1:0] line_pat(input logic [BB-1:0] seed);
    logic [LB-1:0] l;
    for (int k = 0; k < NB; k++) l[k*BB +: BB] = beat_pat(seed, k);
    return l;
  endfunction

  task automatic idle_inputs;
    bus.l1_req_valid    = 1'b0;
    bus.l1_req_type     = 3'd0;
    bus.l1_req_addr     = '0;
    bus.l1_req_wdata    = '0;
    bus.mem_cmd_ready   = 1'b0;
    bus.mem_wdata_ready = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = '0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_req(input logic [2:0] t, input logic [AW-1:0] a, input logic [LB-1:0] d);
    bus.l1_req_valid = 1'b1;
    bus.l1_req_type  = t;
    bus.l1_req_addr  = a;
    bus.l1_req_wdata = d;
    tick();
    bus.l1_req_valid = 1'b0;
  endtask

  task automatic send_rd_beats(input logic [BB-1:0] seed, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = beat_pat(seed, k);
      tick();
    end
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = '0;
  endtask

  task automatic test_reset;
    apply_reset();
    vec_cnt++;
    if (bus.l1_ready !== 1'b1 || bus.l1_resp_valid !== 1'b0 || bus.mem_cmd_valid !== 1'b0 ||
        bus.mem_wdata_valid !== 1'b0 || proto_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: ready=%b resp=%b cmd=%b wv=%b perr=%b, want 1 0 0 0 0",
               bus.l1_ready, bus.l1_resp_valid, bus.mem_cmd_valid, bus.mem_wdata_valid, proto_err);
    end
    vec_cnt++;
    if (stat_reads !== 32'd0 || stat_writebacks !== 32'd0 || bus.l1_resp_rdata !== '0) begin
      err_cnt++;
      $display("FAIL reset_data: reads=%0d wbs=%0d rdata_lo=%h, want 0 0 0",
               stat_reads, stat_writebacks, bus.l1_resp_rdata[63:0]);
    end
  endtask

  task automatic test_read_fill;
    logic [LB-1:0] exp_line;
    int pulses;
    exp_line = line_pat(64'h1111_1111_1111_1111);
    apply_reset();
    send_req(3'd0, 32'h0000_1234, '0);
    vec_cnt++;
    if (bus.mem_cmd_valid !== 1'b1 || bus.mem_cmd_we !== 1'b0 || bus.mem_cmd_addr !== 32'h0000_1200) begin
      err_cnt++;
      $display("FAIL rd_cmd: valid=%b we=%b addr=%h, want 1 0 00001200",
               bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_cmd_addr);
    end
    vec_cnt++;
    if (bus.l1_ready !== 1'b0 || stat_reads !== 32'd1) begin
      err_cnt++;
      $display("FAIL rd_busy: ready=%b reads=%0d, want 0 1", bus.l1_ready, stat_reads);
    end
    bus.mem_cmd_ready = 1'b1;
    tick();
    bus.mem_cmd_ready = 1'b0;
    send_rd_beats(64'h1111_1111_1111_1111, 0, NB - 1);
    vec_cnt++;
    if (bus.l1_resp_valid !== 1'b1 || bus.l1_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL rd_resp_l1: resp=%b ready=%b, want 1 0", bus.l1_resp_valid, bus.l1_ready);
    end
    tick();
    vec_cnt++;
    if (bus.l1_resp_valid !== 1'b0 || bus.l1_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL rd_resp_l2: resp=%b ready=%b, want 0 1", bus.l1_resp_valid, bus.l1_ready);
    end
    vec_cnt++;
    if (bus.l1_resp_rdata[63:0] !== 64'h1111_1111_1111_1111 ||
        bus.l1_resp_rdata[511:448] !== 64'h8888_8888_8888_8888) begin
      err_cnt++;
      $display("FAIL rd_ends: lo=%h hi=%h, want 1111111111111111 8888888888888888",
               bus.l1_resp_rdata[63:0], bus.l1_resp_rdata[511:448]);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.l1_resp_valid === 1'b1) pulses++;
    end
    vec_cnt++;
    if (bus.l1_resp_rdata !== exp_line || pulses != 0) begin
      err_cnt++;
      $display("FAIL rd_hold: rdata_lo=%h extra_pulses=%0d, want %h 0",
               bus.l1_resp_rdata[63:0], pulses, exp_line[63:0]);
    end
  endtask

  task automatic test_writeback;
    logic [LB-1:0] line;
    int b, c, bad_beats;
    bit resp_seen;
    for (int i = 0; i < NB; i++) line[i*BB +: BB] = 64'(i);
    apply_reset();
    send_req(3'd2, 32'h0000_4040, line);
    vec_cnt++;
    if (bus.mem_cmd_valid !== 1'b1 || bus.mem_cmd_we !== 1'b1 || bus.mem_cmd_addr !== 32'h0000_4040) begin
      err_cnt++;
      $display("FAIL wb_cmd: valid=%b we=%b addr=%h, want 1 1 00004040",
               bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_cmd_addr);
    end
    bus.mem_cmd_ready = 1'b1;
    tick();
    bus.mem_cmd_ready = 1'b0;
    b = 0; c = 0; bad_beats = 0; resp_seen = 0;
    while (b < NB && c < 40) begin
      if (bus.mem_wdata_valid !== 1'b1 || bus.mem_wdata !== 64'(b)) begin
        bad_beats++;
        $display("FAIL wb_beat: cycle %0d valid=%b data=%h, want 1 %h", c, bus.mem_wdata_valid,
                 bus.mem_wdata, 64'(b));
      end
      bus.mem_wdata_ready = (c % 2 == 0);
      tick();
      if (bus.mem_wdata_ready) b++;
      c++;
      if (bus.l1_resp_valid === 1'b1) resp_seen = 1;
    end
    bus.mem_wdata_ready = 1'b0;
    vec_cnt++;
    if (bad_beats != 0 || b != NB) begin
      err_cnt++;
      $display("FAIL wb_beats: bad=%0d sent=%0d, want 0 %0d", bad_beats, b, NB);
    end
    vec_cnt++;
    if (bus.l1_ready !== 1'b1 || bus.mem_wdata_valid !== 1'b0 || resp_seen) begin
      err_cnt++;
      $display("FAIL wb_done: ready=%b wv=%b resp_seen=%b, want 1 0 0",
               bus.l1_ready, bus.mem_wdata_valid, resp_seen);
    end
    vec_cnt++;
    if (stat_writebacks !== 32'd1 || stat_reads !== 32'd0) begin
      err_cnt++;
      $display("FAIL wb_stats: wbs=%0d reads=%0d, want 1 0", stat_writebacks, stat_reads);
    end
  endtask

  task automatic test_back_to_back;
    logic [LB-1:0] wline;
    int bad;
    for (int i = 0; i < NB; i++) wline[i*BB +: BB] = 64'(32'h100 + i);
    apply_reset();
    send_req(3'd2, 32'h0000_2000, wline);
    bus.l1_req_valid = 1'b1;
    bus.l1_req_type  = 3'd0;
    bus.l1_req_addr  = 32'h0000_8010;
    bus.l1_req_wdata = '0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.l1_ready !== 1'b0 || bus.mem_cmd_valid !== 1'b1 || bus.mem_cmd_we !== 1'b1 ||
          bus.mem_cmd_addr !== 32'h0000_2000) bad++;
      tick();
    end
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL b2b_cmd_stall: %0d bad cycles, want 0", bad);
    end
    bus.mem_cmd_ready = 1'b1;
    tick();
    bus.mem_cmd_ready = 1'b0;
    bus.mem_wdata_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < NB; i++) begin
      if (bus.l1_ready !== 1'b0 || bus.mem_wdata !== 64'(32'h100 + i)) bad++;
      tick();
    end
    bus.mem_wdata_ready = 1'b0;
    vec_cnt++;
    if (bad != 0 || bus.l1_ready !== 1'b1 || stat_writebacks !== 32'd1) begin
      err_cnt++;
      $display("FAIL b2b_wb: bad=%0d ready=%b wbs=%0d, want 0 1 1", bad, bus.l1_ready, stat_writebacks);
    end
    tick();
    bus.l1_req_valid = 1'b0;
    vec_cnt++;
    if (bus.mem_cmd_valid !== 1'b1 || bus.mem_cmd_we !== 1'b0 || bus.mem_cmd_addr !== 32'h0000_8000) begin
      err_cnt++;
      $display("FAIL b2b_rd_cmd: valid=%b we=%b addr=%h, want 1 0 00008000",
               bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_cmd_addr);
    end
    bus.mem_cmd_ready = 1'b1;
    tick();
    bus.mem_cmd_ready = 1'b0;
    send_rd_beats(64'h0A0B_0C0D_0E0F_1001, 0, NB - 1);
    vec_cnt++;
    if (bus.l1_resp_valid !== 1'b1 || bus.l1_resp_rdata !== line_pat(64'h0A0B_0C0D_0E0F_1001)) begin
      err_cnt++;
      $display("FAIL b2b_rd_resp: resp=%b rdata_lo=%h, want 1 %h", bus.l1_resp_valid,
               bus.l1_resp_rdata[63:0], beat_pat(64'h0A0B_0C0D_0E0F_1001, 0));
    end
    vec_cnt++;
    if (stat_reads !== 32'd1 || stat_writebacks !== 32'd1) begin
      err_cnt++;
      $display("FAIL b2b_stats: reads=%0d wbs=%0d, want 1 1", stat_reads, stat_writebacks);
    end
  endtask

  task automatic test_stray_beat;
    apply_reset();
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = '0;
    vec_cnt++;
    if (proto_err !== 1'b1 || bus.l1_resp_rdata !== '0 || bus.l1_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL stray_idle: perr=%b rdata_lo=%h ready=%b, want 1 0 1",
               proto_err, bus.l1_resp_rdata[63:0], bus.l1_ready);
    end
    send_req(3'd0, 32'h0000_3000, '0);
    bus.mem_cmd_ready = 1'b1;
    tick();
    bus.mem_cmd_ready = 1'b0;
    send_rd_beats(64'h0000_0000_0000_0F0F, 0, NB - 1);
    tick();
    vec_cnt++;
    if (proto_err !== 1'b1 || bus.l1_resp_rdata !== line_pat(64'h0000_0000_0000_0F0F)) begin
      err_cnt++;
      $display("FAIL stray_after_read: perr=%b rdata_lo=%h, want 1 %h",
               proto_err, bus.l1_resp_rdata[63:0], beat_pat(64'h0000_0000_0000_0F0F, 0));
    end
  endtask

  task automatic test_reset_mid_burst;
    int pulses;
    apply_reset();
    send_req(3'd0, 32'h0000_5000, '0);
    bus.mem_cmd_ready = 1'b1;
    tick();
    bus.mem_cmd_ready = 1'b0;
    send_rd_beats(64'h7777_0000_0000_0001, 0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (bus.l1_ready !== 1'b1 || bus.l1_resp_valid !== 1'b0 || bus.l1_resp_rdata !== '0 ||
        bus.mem_cmd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrst_async: ready=%b resp=%b rdata_lo=%h cmd=%b, want 1 0 0 0",
               bus.l1_ready, bus.l1_resp_valid, bus.l1_resp_rdata[63:0], bus.mem_cmd_valid);
    end
    pulses = 0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.l1_resp_valid === 1'b1) pulses++;
    end
    vec_cnt++;
    if (pulses != 0 || bus.l1_ready !== 1'b1 || stat_reads !== 32'd0) begin
      err_cnt++;
      $display("FAIL midrst_quiet: pulses=%0d ready=%b reads=%0d, want 0 1 0",
               pulses, bus.l1_ready, stat_reads);
    end
    send_req(3'd0, 32'h0000_6000, '0);
    bus.mem_cmd_ready = 1'b1;
    tick();
    bus.mem_cmd_ready = 1'b0;
    send_rd_beats(64'h0123_4567_89AB_CDEF, 0, NB - 1);
    vec_cnt++;
    if (bus.l1_resp_valid !== 1'b1 || bus.l1_resp_rdata !== line_pat(64'h0123_4567_89AB_CDEF)) begin
      err_cnt++;
      $display("FAIL midrst_next_read: resp=%b rdata_lo=%h, want 1 %h", bus.l1_resp_valid,
               bus.l1_resp_rdata[63:0], beat_pat(64'h0123_4567_89AB_CDEF, 0));
    end
  endtask

  task automatic test_bad_type;
    int cmd_seen;
    apply_reset();
    send_req(3'd3, 32'h0000_7040, {8{64'h5555_AAAA_5555_AAAA}});
    vec_cnt++;
    if (bus.l1_ready !== 1'b1 || bus.mem_cmd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL badtype_next: ready=%b cmd=%b, want 1 0", bus.l1_ready, bus.mem_cmd_valid);
    end
    cmd_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.mem_cmd_valid !== 1'b0 || bus.mem_wdata_valid !== 1'b0) cmd_seen++;
    end
    vec_cnt++;
    if (cmd_seen != 0 || stat_reads !== 32'd0 || stat_writebacks !== 32'd0) begin
      err_cnt++;
      $display("FAIL badtype_quiet: mem_activity=%0d reads=%0d wbs=%0d, want 0 0 0",
               cmd_seen, stat_reads, stat_writebacks);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_read_fill();
    test_writeback();
    test_back_to_back();
    test_stray_beat();
    test_reset_mid_burst();
    test_bad_type();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
